// File: rtl/ctrl_pool_stride.sv
// Pooling window controller: tracks a raster feature stream and flags every pixel that
// completes a k x k window at stride s, emitting delayed strobes and output coordinates.
module ctrl_pool_stride #(
    parameter int LWIDTH = 10,
    parameter int D_POOL = 3
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              in_begin,
    input  logic              in_valid,
    input  logic              in_end,
    input  logic [LWIDTH-1:0] w_fea_size,
    input  logic [LWIDTH-1:0] h_fea_size,
    input  logic [LWIDTH-1:0] pool_size,
    input  logic [LWIDTH-1:0] pool_stride,
    output logic              buf_feat_en,
    output logic              pool_oe,
    output logic              out_begin,
    output logic              out_valid,
    output logic              out_end,
    output logic [LWIDTH-1:0] out_x,
    output logic [LWIDTH-1:0] out_y,
    output logic              busy,
    output logic              cfg_err,
    output logic              seq_err
);
    // Tag layout: {hit, first, last, ox, oy}
    localparam int TW = 3 + 2 * LWIDTH;

    typedef enum logic [1:0] {S_WAIT, S_ACTIVE, S_DRAIN} state_t;
    state_t state_reg, state_next;

    logic [LWIDTH-1:0] w_reg, h_reg, k_reg, s_reg;
    logic [LWIDTH-1:0] x_reg, y_reg, px_reg, py_reg, ox_reg, oy_reg;
    logic              first_reg, end_seen_reg;
    logic              buf_feat_en_reg, cfg_err_reg, seq_err_reg;

    logic              cfg_ok, start, pix, x_wrap, final_pix, abort;
    logic              hit, last_col, last_row;
    logic [LWIDTH-1:0] km1;
    logic [TW-1:0]     tag, tail;

    assign cfg_ok = (pool_size != '0) && (pool_stride != '0) &&
                    (pool_size <= w_fea_size) && (pool_size <= h_fea_size);
    assign start     = (state_reg == S_WAIT) && in_begin && cfg_ok;
    assign pix       = (state_reg == S_ACTIVE) && in_valid;
    assign x_wrap    = (x_reg == w_reg - 1'b1);
    assign final_pix = pix && x_wrap && (y_reg == h_reg - 1'b1);
    assign abort     = (state_reg == S_ACTIVE) && in_end && !final_pix;
    assign km1       = k_reg - 1'b1;

    assign hit      = pix && (x_reg >= km1) && (px_reg == '0) && (y_reg >= km1) && (py_reg == '0);
    // One extra bit so coordinate + stride cannot wrap around
    assign last_col = hit && (({1'b0, x_reg} + {1'b0, s_reg}) >= {1'b0, w_reg});
    assign last_row = hit && (({1'b0, y_reg} + {1'b0, s_reg}) >= {1'b0, h_reg});
    assign tag      = {hit, hit && first_reg, last_col && last_row,
                       hit ? ox_reg : '0, hit ? oy_reg : '0};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_WAIT:   if (start) state_next = S_ACTIVE;
            S_ACTIVE: begin
                if (abort)          state_next = S_WAIT;
                else if (final_pix) state_next = S_DRAIN;
            end
            // The last window may finish well before the last pixel of the frame
            S_DRAIN:  if (out_end || end_seen_reg) state_next = S_WAIT;
            default:  state_next = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_reg       <= S_WAIT;
            w_reg           <= '0;
            h_reg           <= '0;
            k_reg           <= '0;
            s_reg           <= '0;
            x_reg           <= '0;
            y_reg           <= '0;
            px_reg          <= '0;
            py_reg          <= '0;
            ox_reg          <= '0;
            oy_reg          <= '0;
            first_reg       <= 1'b0;
            end_seen_reg    <= 1'b0;
            buf_feat_en_reg <= 1'b0;
            cfg_err_reg     <= 1'b0;
            seq_err_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            buf_feat_en_reg <= start;
            cfg_err_reg     <= (state_reg == S_WAIT) && in_begin && !cfg_ok;
            seq_err_reg     <= abort;
            if (start) begin
                w_reg        <= w_fea_size;
                h_reg        <= h_fea_size;
                k_reg        <= pool_size;
                s_reg        <= pool_stride;
                x_reg        <= '0;
                y_reg        <= '0;
                px_reg       <= '0;
                py_reg       <= '0;
                ox_reg       <= '0;
                oy_reg       <= '0;
                first_reg    <= 1'b1;
                end_seen_reg <= 1'b0;
            end else if (pix) begin
                if (x_wrap) begin
                    x_reg  <= '0;
                    px_reg <= '0;
                    y_reg  <= y_reg + 1'b1;
                    if (y_reg >= km1)
                        py_reg <= (py_reg + 1'b1 == s_reg) ? '0 : py_reg + 1'b1;
                end else begin
                    x_reg <= x_reg + 1'b1;
                    if (x_reg >= km1)
                        px_reg <= (px_reg + 1'b1 == s_reg) ? '0 : px_reg + 1'b1;
                end
                if (hit) begin
                    first_reg <= 1'b0;
                    if (last_col) begin
                        ox_reg <= '0;
                        oy_reg <= oy_reg + 1'b1;
                    end else begin
                        ox_reg <= ox_reg + 1'b1;
                    end
                end
            end
            if ((state_reg == S_ACTIVE) && out_end)
                end_seen_reg <= 1'b1;
        end
    end

    // Tag delay line; an aborted frame flushes every pending tag
    for (genvar gi = 0; gi < D_POOL; gi++) begin : g_dly
        logic [TW-1:0] stage_reg;
        logic [TW-1:0] stage_in;
        if (gi == 0) begin : g_head
            assign stage_in = tag;
        end else begin : g_link
            assign stage_in = g_dly[gi-1].stage_reg;
        end
        always_ff @(posedge clk or negedge xrst) begin
            if (!xrst)
                stage_reg <= '0;
            else if (abort)
                stage_reg <= '0;
            else
                stage_reg <= stage_in;
        end
    end

    assign tail        = g_dly[D_POOL-1].stage_reg;
    assign pool_oe     = g_dly[D_POOL-2].stage_reg[TW-1];
    assign out_valid   = tail[TW-1];
    assign out_begin   = tail[TW-2];
    assign out_end     = tail[TW-3];
    assign out_x       = tail[2*LWIDTH-1:LWIDTH];
    assign out_y       = tail[LWIDTH-1:0];
    assign buf_feat_en = buf_feat_en_reg;
    assign cfg_err     = cfg_err_reg;
    assign seq_err     = seq_err_reg;
    assign busy        = (state_reg != S_WAIT);

endmodule

// File: tb/tb_ctrl_pool_stride.sv
// Directed bench for ctrl_pool_stride: frames with hand-computed hit positions,
// configuration rejects, early abort and asynchronous reset mid-frame.
module tb_ctrl_pool_stride;
    localparam int LW = 10;
    localparam int DP = 3;

    logic          clk = 1'b0;
    logic          xrst = 1'b0;
    logic          in_begin = 1'b0, in_valid = 1'b0, in_end = 1'b0;
    logic [LW-1:0] w_fea_size = '0, h_fea_size = '0, pool_size = '0, pool_stride = '0;
    logic          buf_feat_en, pool_oe, out_begin, out_valid, out_end, busy, cfg_err, seq_err;
    logic [LW-1:0] out_x, out_y;

    ctrl_pool_stride #(.LWIDTH(LW), .D_POOL(DP)) dut (
        .clk(clk), .xrst(xrst),
        .in_begin(in_begin), .in_valid(in_valid), .in_end(in_end),
        .w_fea_size(w_fea_size), .h_fea_size(h_fea_size),
        .pool_size(pool_size), .pool_stride(pool_stride),
        .buf_feat_en(buf_feat_en), .pool_oe(pool_oe),
        .out_begin(out_begin), .out_valid(out_valid), .out_end(out_end),
        .out_x(out_x), .out_y(out_y),
        .busy(busy), .cfg_err(cfg_err), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Event log sampled on the falling edge
    int ov_cyc[$], ov_x[$], ov_y[$], ov_b[$], ov_e[$];
    int oe_cyc[$], bf_cyc[$], ce_cyc[$], se_cyc[$];
    int busy_fall = -1;
    bit busy_prev = 1'b0;
    bit busy_seen = 1'b0;

    always @(negedge clk) begin
        if (out_valid) begin
            ov_cyc.push_back(cyc);
            ov_x.push_back(int'(out_x));
            ov_y.push_back(int'(out_y));
            ov_b.push_back(int'(out_begin));
            ov_e.push_back(int'(out_end));
        end
        if (pool_oe)     oe_cyc.push_back(cyc);
        if (buf_feat_en) bf_cyc.push_back(cyc);
        if (cfg_err)     ce_cyc.push_back(cyc);
        if (seq_err)     se_cyc.push_back(cyc);
        if (busy_prev && !busy) busy_fall = cyc;
        if (busy) busy_seen = 1'b1;
        busy_prev = busy;
    end

    task automatic clear_log();
        ov_cyc.delete(); ov_x.delete(); ov_y.delete(); ov_b.delete(); ov_e.delete();
        oe_cyc.delete(); bf_cyc.delete(); ce_cyc.delete(); se_cyc.delete();
        busy_fall = -1;
        busy_seen = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic longint all_outs();
        return {buf_feat_en, pool_oe, out_begin, out_valid, out_end, busy, cfg_err, seq_err,
                out_x, out_y};
    endfunction

    int exp_idx[$], exp_x[$], exp_y[$];
    int pix_cyc[64];

    // Drives one frame (optionally gapped / aborted at a pixel) and checks the logged outputs
    task automatic run_frame(input string name, input int w, input int h, input int k,
                             input int s, input bit gap, input int abort_at, input bit poke);
        int npix, bcyc, last_pix, last_out, exp_fall, n;
        clear_log();
        w_fea_size = LW'(w); h_fea_size = LW'(h); pool_size = LW'(k); pool_stride = LW'(s);
        in_begin = 1'b1;
        bcyc = cyc;
        @(posedge clk);
        #1;
        in_begin = 1'b0;
        npix = (abort_at >= 0) ? abort_at + 1 : w * h;
        for (int i = 0; i < npix; i++) begin
            in_valid = 1'b1;
            in_end   = (i == npix - 1);
            if (poke && i == 3) begin
                in_begin  = 1'b1;
                pool_size = '0;
            end
            pix_cyc[i] = cyc;
            @(posedge clk);
            #1;
            in_valid  = 1'b0;
            in_end    = 1'b0;
            in_begin  = 1'b0;
            pool_size = LW'(k);
            if (gap) begin
                @(posedge clk);
                #1;
            end
        end
        last_pix = pix_cyc[npix-1];
        for (int t = 0; t < 40 && busy; t++) begin
            @(posedge clk);
            #1;
        end
        check_eq({name, " busy_timeout"}, busy, 0);
        idle(4);

        n = exp_idx.size();
        check_eq({name, " out_count"}, ov_cyc.size(), n);
        check_eq({name, " oe_count"}, oe_cyc.size(), n);
        for (int i = 0; i < n && i < ov_cyc.size(); i++) begin
            check_eq($sformatf("%s out%0d_cycle", name, i), ov_cyc[i], pix_cyc[exp_idx[i]] + DP);
            check_eq($sformatf("%s out%0d_x", name, i), ov_x[i], exp_x[i]);
            check_eq($sformatf("%s out%0d_y", name, i), ov_y[i], exp_y[i]);
            check_eq($sformatf("%s out%0d_begin", name, i), ov_b[i], (i == 0) ? 1 : 0);
            check_eq($sformatf("%s out%0d_end", name, i), ov_e[i],
                     (i == n - 1 && abort_at < 0) ? 1 : 0);
            if (i < oe_cyc.size())
                check_eq($sformatf("%s oe%0d_cycle", name, i), oe_cyc[i],
                         pix_cyc[exp_idx[i]] + DP - 1);
        end
        check_eq({name, " buf_feat_en_count"}, bf_cyc.size(), 1);
        check_eq({name, " buf_feat_en_cycle"}, (bf_cyc.size() > 0) ? bf_cyc[0] : -1, bcyc + 1);
        check_eq({name, " cfg_err_count"}, ce_cyc.size(), 0);
        check_eq({name, " seq_err_count"}, se_cyc.size(), (abort_at >= 0) ? 1 : 0);
        if (abort_at >= 0) begin
            check_eq({name, " seq_err_cycle"}, (se_cyc.size() > 0) ? se_cyc[0] : -1, last_pix + 1);
            exp_fall = last_pix + 1;
        end else begin
            last_out = pix_cyc[exp_idx[n-1]] + DP;
            exp_fall = (last_out + 1 > last_pix + 2) ? last_out + 1 : last_pix + 2;
        end
        check_eq({name, " busy_fall_cycle"}, busy_fall, exp_fall);
        $display("frame %s: %0d outputs logged", name, ov_cyc.size());
    endtask

    task automatic bad_cfg(input string name, input int w, input int h, input int k, input int s);
        int bcyc;
        clear_log();
        w_fea_size = LW'(w); h_fea_size = LW'(h); pool_size = LW'(k); pool_stride = LW'(s);
        in_begin = 1'b1;
        bcyc = cyc;
        @(posedge clk);
        #1;
        in_begin = 1'b0;
        idle(4);
        check_eq({name, " cfg_err_count"}, ce_cyc.size(), 1);
        check_eq({name, " cfg_err_cycle"}, (ce_cyc.size() > 0) ? ce_cyc[0] : -1, bcyc + 1);
        check_eq({name, " buf_feat_en_count"}, bf_cyc.size(), 0);
        check_eq({name, " busy_seen"}, busy_seen, 0);
        $display("config %s: cfg_err pulses %0d", name, ce_cyc.size());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        check_eq("reset_outputs", all_outs(), 0);
        xrst = 1'b1;
        idle(2);

        exp_idx = '{5, 7, 13, 15}; exp_x = '{0, 1, 0, 1}; exp_y = '{0, 0, 1, 1};
        run_frame("f4x4_k2s2", 4, 4, 2, 2, 1'b0, -1, 1'b1);

        exp_idx = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
        exp_x   = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
        exp_y   = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
        run_frame("f5x5_k3s1", 5, 5, 3, 1, 1'b0, -1, 1'b0);

        exp_idx = '{6, 9, 21, 24}; exp_x = '{0, 1, 0, 1}; exp_y = '{0, 0, 1, 1};
        run_frame("f5x5_k2s3", 5, 5, 2, 3, 1'b0, -1, 1'b0);

        exp_idx = '{7, 9, 11}; exp_x = '{0, 1, 2}; exp_y = '{0, 0, 0};
        run_frame("f6x3_k2s2_gap", 6, 3, 2, 2, 1'b1, -1, 1'b0);

        bad_cfg("cfg_k0", 5, 5, 0, 1);
        bad_cfg("cfg_k6", 5, 5, 6, 1);

        exp_idx = '{5}; exp_x = '{0}; exp_y = '{0};
        run_frame("abort_at8", 4, 4, 2, 2, 1'b0, 8, 1'b0);

        // Asynchronous reset while a window is in flight
        clear_log();
        w_fea_size = 10'd4; h_fea_size = 10'd4; pool_size = 10'd2; pool_stride = 10'd2;
        in_begin = 1'b1;
        @(posedge clk);
        #1;
        in_begin = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        check_eq("rst_mid pool_oe_before", pool_oe, 1);
        #2;
        xrst = 1'b0;
        #1;
        check_eq("rst_mid outputs_zero", all_outs(), 0);
        @(posedge clk);
        #1;
        xrst = 1'b1;
        idle(2);
        $display("reset mid-frame applied and released");

        exp_idx = '{6, 9, 21, 24}; exp_x = '{0, 1, 0, 1}; exp_y = '{0, 0, 1, 1};
        run_frame("post_rst_5x5_k2s3", 5, 5, 2, 3, 1'b0, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ctrl_pool_stride.md
# ctrl_pool_stride

Parametrised pooling controller for the renkon pooling stage, replacing the fixed square, stride-equals-size control. It tracks a raster-order feature stream of configurable width and height and flags every pixel that completes a k×k window at stride s. It emits delayed begin/valid/end strobes, an operand-enable, and output-map coordinates to the pooling datapath. It sits between the feature line buffer and the max-pool datapath.

## Interface
Parameters:
- LWIDTH, 10, width of all size, stride, counter and coordinate fields
- D_POOL, 3, latency in cycles from sampling a completing pixel to out_valid; must be ≥ 2

Ports:
- clk  in  1  clock, all flops on rising edge
- xrst  in  1  reset, asynchronous, active-low
- in_begin  in  1  frame start pulse; configuration inputs are sampled on this cycle
- in_valid  in  1  one feature pixel present this cycle (raster order, x fastest)
- in_end  in  1  frame end marker, driven together with the final in_valid
- w_fea_size  in  LWIDTH  feature map width W
- h_fea_size  in  LWIDTH  feature map height H
- pool_size  in  LWIDTH  window edge k
- pool_stride  in  LWIDTH  stride s
- buf_feat_en  out  1  one-cycle pulse, one cycle after an accepted in_begin
- pool_oe  out  1  datapath output-register enable, one cycle ahead of out_valid
- out_begin  out  1  with the first out_valid of a frame
- out_valid  out  1  pooled pixel valid
- out_end  out  1  with the last out_valid of a frame
- out_x, out_y  out  LWIDTH  output-map coordinates of the current out_valid
- busy  out  1  high in S_ACTIVE and S_DRAIN
- cfg_err  out  1  one-cycle pulse on a rejected in_begin
- seq_err  out  1  one-cycle pulse on a premature in_end

## Operation
- FSM states: S_WAIT, S_ACTIVE, S_DRAIN. Reset state is S_WAIT.
- S_WAIT → S_ACTIVE on in_begin when the configuration is legal: k ≥ 1, s ≥ 1, k ≤ W, k ≤ H. Configuration is latched on that cycle.
- Illegal configuration on in_begin: pulse cfg_err the next cycle, stay in S_WAIT, no buf_feat_en.
- in_begin while in S_ACTIVE or S_DRAIN is ignored.
- Position counters x (0..W-1) and y (0..H-1) advance on in_valid in S_ACTIVE only. x wraps to 0 at W-1 and y then increments.
- Phase counters px and py:
  - Each is held at 0 until its coordinate reaches k-1.
  - From there it counts modulo s.
  - px restarts at every row start; py restarts at frame start.
- Hit: in_valid && x ≥ k-1 && px == 0 && y ≥ k-1 && py == 0.
- Last-hit column: hit && x+s ≥ W. Last-hit row: hit && y+s ≥ H. Both comparisons are evaluated at LWIDTH+1 bits, with no division.
- A hit pushes into the D_POOL-deep delay line a tag {hit, first, last, ox, oy}:
  - first = first hit of the frame.
  - last = last-hit column && last-hit row.
  - ox and oy are output counters: ox increments per hit and resets on the last-hit column; oy increments per completed output row.
- S_ACTIVE → S_DRAIN when in_valid is sampled at x=W-1, y=H-1.
- S_DRAIN → S_WAIT on the cycle out_end is asserted.
- in_valid is ignored outside S_ACTIVE.
- in_end in S_ACTIVE not coinciding with the final pixel (early abort):
  - Pulse seq_err.
  - Clear the delay line, so no out_* pulses for pending tags.
  - Go to S_WAIT.
- Gaps in in_valid are legal; the counters hold.

## Timing
- Reset value: all outputs 0 (including out_x and out_y); counters, delay line and latched configuration 0.
- An asynchronous xrst mid-frame clears everything immediately. The first legal in_begin after release restarts cleanly.
- buf_feat_en: cycle N+1 for an accepted in_begin at cycle N.
- Hit pixel sampled at cycle N: pool_oe at N+D_POOL-1; out_valid, out_x and out_y at N+D_POOL.
- out_begin and out_end are aligned to their out_valid cycle. For a single-output frame both are high on the same cycle.
- Output count per frame: (⌊(W-k)/s⌋+1) × (⌊(H-k)/s⌋+1). Pixels beyond the last hit produce nothing.
- A new in_begin is accepted only after the S_DRAIN → S_WAIT transition (the cycle after out_end).

## Test plan
- W=H=4, k=2, s=2, continuous in_valid 0..15: hits at pixel indices 5, 7, 13 and 15; out_valid at index+D_POOL; (out_x, out_y) = (0,0), (1,0), (0,1), (1,1); out_begin at the first output, out_end at the last; busy drops the cycle after out_end.
- W=H=5, k=3, s=1: 9 outputs, first at pixel index 12, last at pixel index 24.
- W=H=5, k=2, s=3: hits at x,y ∈ {1,4}, giving 4 outputs at pixel indices 6, 9, 21 and 24.
- W=6, H=3, k=2, s=2, with in_valid toggling every other cycle: 3 outputs at pixel indices 7, 9 and 11; out_end at the third output; pixel row y=2 produces nothing.
- in_begin with k=0, and separately with k=6 > W=5: cfg_err pulse, no buf_feat_en, busy stays 0.
- Two abort cases:
  - in_end at pixel 8 of a 4×4, k=2, s=2 frame: seq_err pulse, no further out_valid, S_WAIT.
  - xrst asserted mid-frame: all outputs 0 immediately; the next frame runs correctly.
